// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC generation, credit-limited imem requests, in-order response buffer.
// Optional macro FETCH_JUMP_PREDICT_EN enables self-redirect on j/jal words as they are buffered.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [5:0]  instr_op_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_buf_count;
  logic [PW-1:0] r_buf_wr;
  logic [PW-1:0] r_buf_rd;
  logic [PW-1:0] r_tag_wr;
  logic [PW-1:0] r_tag_rd;
  logic [31:0]   r_buf_instr [BUF_DEPTH];
  logic [31:0]   r_buf_pc    [BUF_DEPTH];
  logic [31:0]   r_tag_pc    [BUF_DEPTH];

  logic          w_run;
  logic          w_grant;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic          w_buf_valid;
  logic          w_self_redirect;
  logic          w_redirect;
  logic [31:0]   w_redirect_pc;
  logic [31:0]   w_rsp_pc;
  logic [CW-1:0] w_out_next;
  logic [CW:0]   w_credit_used;

  assign w_run         = (r_state == S_RUN);
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_buf_count};
  assign imem_req_o    = w_run && (w_credit_used < (CW+1)'(BUF_DEPTH));
  assign imem_addr_o   = imem_req_o ? r_fetch_pc : 32'd0;

  assign w_grant     = imem_req_o & imem_gnt_i;
  assign w_rsp       = imem_rvalid_i && (r_outstanding != '0);
  assign w_rsp_pc    = r_tag_pc[r_tag_rd];
  assign w_push      = w_run & w_rsp & ~redirect_i;
  assign w_buf_valid = (r_buf_count != '0);
  assign w_pop       = w_buf_valid & instr_ready_i;
  assign w_out_next  = r_outstanding + CW'(w_grant) - CW'(w_rsp);

`ifdef FETCH_JUMP_PREDICT_EN
  logic [31:0] w_rsp_pc_plus4;
  logic [31:0] w_jump_pc;
  assign w_rsp_pc_plus4  = w_rsp_pc + 32'd4;
  assign w_jump_pc       = {w_rsp_pc_plus4[31:28], imem_rdata_i[25:0], 2'b00};
  // j = 000010, jal = 000011; external redirect takes priority
  assign w_self_redirect = w_push && (imem_rdata_i[31:27] == 5'b00001);
  assign w_redirect_pc   = redirect_i ? redirect_pc_i : w_jump_pc;
`else
  assign w_self_redirect = 1'b0;
  assign w_redirect_pc   = redirect_pc_i;
`endif

  assign w_redirect = redirect_i | w_self_redirect;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state       <= S_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_buf_count   <= '0;
      r_buf_wr      <= '0;
      r_buf_rd      <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      // Tag FIFO tracks every granted PC, so stale responses pop it in order too.
      if (w_grant) r_tag_wr <= r_tag_wr + PW'(1);
      if (w_rsp)   r_tag_rd <= r_tag_rd + PW'(1);

      if (w_redirect)   r_fetch_pc <= w_redirect_pc & ~32'd3;
      else if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;

      if (redirect_i) begin
        r_buf_count <= '0;
        r_buf_wr    <= '0;
        r_buf_rd    <= '0;
      end else begin
        if (w_push) r_buf_wr <= r_buf_wr + PW'(1);
        if (w_pop)  r_buf_rd <= r_buf_rd + PW'(1);
        r_buf_count <= r_buf_count + CW'(w_push) - CW'(w_pop);
      end

      case (r_state)
        S_BOOT:  r_state <= S_RUN;
        S_RUN: begin
          if (w_redirect && (w_out_next != '0)) begin
            r_state   <= S_DRAIN;
            r_discard <= w_out_next;
          end
        end
        S_DRAIN: begin
          if (w_rsp) begin
            r_discard <= r_discard - CW'(1);
            if (r_discard <= CW'(1)) r_state <= S_RUN;
          end else if (r_discard == '0) begin
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  // Payload storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_buf_instr[r_buf_wr] <= imem_rdata_i;
      r_buf_pc[r_buf_wr]    <= w_rsp_pc;
    end
    if (w_grant) r_tag_pc[r_tag_wr] <= r_fetch_pc;
  end

  assign instr_valid_o = w_buf_valid;
  assign instr_o       = w_buf_valid ? r_buf_instr[r_buf_rd] : 32'd0;
  assign pc_o          = w_buf_valid ? r_buf_pc[r_buf_rd] : 32'd0;
  assign pc_plus4_o    = w_buf_valid ? (r_buf_pc[r_buf_rd] + 32'd4) : 32'd0;
  assign instr_op_o    = instr_o[31:26];

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(w_push && !w_pop && (r_buf_count == CW'(BUF_DEPTH))));
  a_rvalid_tracked: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(imem_rvalid_i && (r_outstanding == '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order instruction memory model.
// Expected jump behaviour follows FETCH_JUMP_PREDICT_EN when the bench is built with it.
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [5:0]  instr_op_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          grant_cnt = 0;
  bit          rsp_en = 1'b1;
  logic [31:0] pend_q [$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_op_o    (instr_op_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory image: a j to 0x100 at address 0, otherwise addi-coded words tagged with the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'd0) ? 32'h0800_0040 : {6'h08, a[27:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; advances one cycle and returns at the next falling edge.
  task automatic step();
    logic        g;
    logic [31:0] ga;
    #4;
    g  = imem_req_o & imem_gnt_i;
    ga = imem_addr_o;
    @(posedge clk_i);
    #1;
    if (g && rst_i) begin
      pend_q.push_back(ga);
      grant_cnt++;
    end
    if (rsp_en && pend_q.size() > 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend_q.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'd0;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i         = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'd0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    instr_ready_i = 1'b0;
    rsp_en        = 1'b1;
    pend_q.delete();
    step();
    step();
    grant_cnt = 0;
  endtask

  task automatic deliver_one(input logic [31:0] exp_pc);
    int          n;
    logic [31:0] w;
    n = 0;
    while (!(instr_valid_o && instr_ready_i) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      chk("deliver_timeout", {31'd0, instr_valid_o}, 32'd1);
    end else begin
      w = mem_word(exp_pc);
      $display("[TB] deliver pc=%h instr=%h pc_plus4=%h", pc_o, instr_o, pc_plus4_o);
      chk("pc", pc_o, exp_pc);
      chk("instr", instr_o, w);
      chk("op", {26'd0, instr_op_o}, {26'd0, w[31:26]});
      chk("pc_plus4", pc_plus4_o, exp_pc + 32'd4);
      step();
    end
  endtask

  initial begin
    int n;
    bit saw_valid;

    // Reset state
    do_reset();
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_pc4", pc_plus4_o, 32'd0);
    imem_gnt_i    = 1'b1;
    instr_ready_i = 1'b1;
    rst_i         = 1'b1;
    chk("boot_req", {31'd0, imem_req_o}, 32'd0);
    step();
    chk("run_req", {31'd0, imem_req_o}, 32'd1);
    chk("run_addr", imem_addr_o, 32'h100);
    for (int i = 0; i < 4; i++) deliver_one(32'h100 + 32'(i * 4));

    // Backpressure: two grants fill the credit, buffer holds steady
    do_reset();
    imem_gnt_i = 1'b1;
    rst_i      = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("bp_grants", 32'(grant_cnt), 32'd2);
    chk("bp_req", {31'd0, imem_req_o}, 32'd0);
    chk("bp_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("bp_pc", pc_o, 32'h100);
    chk("bp_instr", instr_o, mem_word(32'h100));
    step();
    step();
    chk("bp_hold_pc", pc_o, 32'h100);
    instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) deliver_one(32'h100 + 32'(i * 4));

    // Redirect with two outstanding requests: both responses dropped
    do_reset();
    rsp_en        = 1'b0;
    imem_gnt_i    = 1'b1;
    instr_ready_i = 1'b1;
    rst_i         = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("dr_grants", 32'(grant_cnt), 32'd2);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_2003;
    step();
    redirect_i = 1'b0;
    chk("dr_req_off", {31'd0, imem_req_o}, 32'd0);
    rsp_en    = 1'b1;
    n         = 0;
    saw_valid = 1'b0;
    while (!imem_req_o && n < 12) begin
      if (instr_valid_o) saw_valid = 1'b1;
      step();
      n++;
    end
    chk("dr_no_valid", {31'd0, saw_valid}, 32'd0);
    chk("dr_addr", imem_addr_o, 32'h2000);
    deliver_one(32'h2000);
    deliver_one(32'h2004);

    // Redirect coinciding with both a response and a grant
    do_reset();
    imem_gnt_i    = 1'b1;
    instr_ready_i = 1'b1;
    rst_i         = 1'b1;
    step();
    step();
    chk("co_addr", imem_addr_o, 32'h104);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_3000;
    step();
    redirect_i = 1'b0;
    chk("co_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("co_req", {31'd0, imem_req_o}, 32'd0);
    deliver_one(32'h3000);
    deliver_one(32'h3004);

    // PC wrap at the top of the address space
    do_reset();
    instr_ready_i = 1'b1;
    rst_i         = 1'b1;
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    chk("wr_req", {31'd0, imem_req_o}, 32'd1);
    chk("wr_addr0", imem_addr_o, 32'hFFFF_FFFC);
    imem_gnt_i = 1'b1;
    step();
    chk("wr_addr1", imem_addr_o, 32'h0000_0000);
    deliver_one(32'hFFFF_FFFC);

    // Jump word at pc 0
    do_reset();
    instr_ready_i = 1'b1;
    rst_i         = 1'b1;
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0000;
    step();
    redirect_i = 1'b0;
    imem_gnt_i = 1'b1;
    deliver_one(32'h0000_0000);
`ifdef FETCH_JUMP_PREDICT_EN
    deliver_one(32'h0000_0100);
`else
    deliver_one(32'h0000_0004);
`endif

    // Asynchronous reset mid-stream clears outputs without a clock edge
    step();
    rst_i = 1'b0;
    #1;
    chk("ar_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("ar_req", {31'd0, imem_req_o}, 32'd0);
    chk("ar_pc", pc_o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
